// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver constants (FSM encoding, frame width, bus register addresses).
package ps2_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;
    localparam int PS2_DATA_BITS = 8;
    localparam logic [31:0] KBD_DATA_ADDR  = 32'h8000_3000;
    localparam logic [31:0] KBD_VALID_ADDR = 32'h8000_3001;
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: circular FIFO for received scan codes.
// Ports: clk, rst_n (async active-low), push/din write, pop read-advance,
// full/empty flags, head = oldest entry (zero when empty).
module ps2_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic wr, rd;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    // A push while full is only accepted when a pop frees the head slot in the same cycle.
    assign wr = push && (!full || pop);
    assign rd = pop && !empty;
    always_comb begin
        mem_d = mem_q;
        if (wr) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/ps2_keyboard_receiver.sv
// ps2_keyboard_receiver: PS/2 device-to-host frame receiver with scan-code FIFO.
// Ports: clk, rst_n (async active-low), ps2_clk/ps2_data raw pins,
// keyboard_readed_signal pop request, keyboard_data FIFO head, keyboard_valid_data
// non-empty flag, frame_error / overflow one-cycle pulses.
module ps2_keyboard_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       keyboard_readed_signal,
    output logic [7:0] keyboard_data,
    output logic       keyboard_valid_data,
    output logic       frame_error,
    output logic       overflow
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int CW = $clog2(PS2_DATA_BITS);
    logic ck_meta_q, ck_meta_d, ck_sync_q, ck_sync_d;
    logic dt_meta_q, dt_meta_d, dt_sync_q, dt_sync_d;
    logic ck_prev_q, ck_prev_d, fall_q, fall_d;
    logic [1:0] state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic frame_error_q, frame_error_d, overflow_q, overflow_d;
    logic push, full, empty, frame_ok, timeout;
    assign frame_ok = dt_sync_q && ^{shift_q, parity_q};
    assign timeout  = state_q != ST_IDLE && !fall_q && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    always_comb begin
        ck_meta_d     = ps2_clk;
        ck_sync_d     = ck_meta_q;
        dt_meta_d     = ps2_data;
        dt_sync_d     = dt_meta_q;
        ck_prev_d     = ck_sync_q;
        fall_d        = ck_prev_q && !ck_sync_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        push          = 1'b0;
        frame_error_d = 1'b0;
        tmo_d         = (fall_q || state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
        if (timeout) begin
            state_d       = ST_IDLE;
            frame_error_d = 1'b1;
        end else if (fall_q) begin
            case (state_q)
                ST_IDLE: begin
                    // A high data line at a falling edge is not a start bit; ignore it.
                    if (!dt_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dt_sync_q, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = dt_sync_q;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d       = ST_IDLE;
                    push          = frame_ok;
                    frame_error_d = !frame_ok;
                end
            endcase
        end
        // When full, a same-cycle pop makes room, so only an unaccompanied push overflows.
        overflow_d = push && full && !keyboard_readed_signal;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_meta_q     <= 1'b1;
            ck_sync_q     <= 1'b1;
            dt_meta_q     <= 1'b1;
            dt_sync_q     <= 1'b1;
            ck_prev_q     <= 1'b1;
            fall_q        <= 1'b0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tmo_q         <= '0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            ck_meta_q     <= ck_meta_d;
            ck_sync_q     <= ck_sync_d;
            dt_meta_q     <= dt_meta_d;
            dt_sync_q     <= dt_sync_d;
            ck_prev_q     <= ck_prev_d;
            fall_q        <= fall_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tmo_q         <= tmo_d;
            frame_error_q <= frame_error_d;
            overflow_q    <= overflow_d;
        end
    end
    ps2_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PS2_DATA_BITS)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (shift_q),
        .pop   (keyboard_readed_signal),
        .full  (full),
        .empty (empty),
        .head  (keyboard_data)
    );
    assign keyboard_valid_data = !empty;
    assign frame_error         = frame_error_q;
    assign overflow            = overflow_q;
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// tb_ps2_keyboard_receiver: directed, table-driven bench for ps2_keyboard_receiver.
module tb_ps2_keyboard_receiver;
    localparam int T = 200;
    localparam int H = 20;
    logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, rd = 1'b0;
    logic [7:0] keyboard_data;
    logic keyboard_valid_data, frame_error, overflow;
    int nvec = 0, nbad = 0, err_cnt = 0, ovf_cnt = 0;
    always #5 clk = ~clk;
    ps2_keyboard_receiver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(T)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ps2_clk                (ps2_clk),
        .ps2_data               (ps2_data),
        .keyboard_readed_signal (rd),
        .keyboard_data          (keyboard_data),
        .keyboard_valid_data    (keyboard_valid_data),
        .frame_error            (frame_error),
        .overflow               (overflow)
    );
    always @(negedge clk) begin
        if (frame_error) err_cnt++;
        if (overflow) ovf_cnt++;
    end
    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_head;
        int         exp_err;
        int         exp_ovf;
    } vec_t;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask
    task automatic send_head(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d ^ bad_par);
    endtask
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        send_head(d, bad_par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask
    task automatic pop1;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask
    task automatic drain(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        logic [7:0] exp [4];
        exp = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_head%0d", i), keyboard_data, exp[i]);
            pop1();
        end
        chk("drain_valid", keyboard_valid_data, 0);
        chk("drain_data", keyboard_data, 0);
    endtask
    vec_t vecs [7];
    initial begin
        int e0, o0, k;
        vecs[0] = '{8'hF0, 1'b1, 1'b1, 1'b0, 8'h00, 1, 0};
        vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0};
        vecs[2] = '{8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 0, 0};
        vecs[3] = '{8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 0, 0};
        vecs[4] = '{8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 0, 0};
        vecs[5] = '{8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 0, 0};
        vecs[6] = '{8'h55, 1'b0, 1'b1, 1'b1, 8'h11, 0, 1};
        repeat (3) @(negedge clk);
        chk("rst_data", keyboard_data, 0);
        chk("rst_valid", keyboard_valid_data, 0);
        chk("rst_err", frame_error, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);
        // Reset in the middle of a frame must discard it.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_valid", keyboard_valid_data, 0);
        chk("midrst_data", keyboard_data, 0);
        chk("midrst_err", frame_error, 0);
        e0 = err_cnt;
        // 0x1C with exact pin-to-valid latency: 2 sync stages + edge register + push edge.
        send_head(8'h1C, 1'b0);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("lat_valid_early", keyboard_valid_data, 0);
        @(negedge clk);
        chk("lat_valid", keyboard_valid_data, 1);
        chk("lat_data", keyboard_data, 8'h1C);
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        chk("1c_noerr", err_cnt - e0, 0);
        pop1();
        chk("pop_valid", keyboard_valid_data, 0);
        chk("pop_data", keyboard_data, 0);
        for (int i = 0; i < 7; i++) begin
            e0 = err_cnt;
            o0 = ovf_cnt;
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop);
            chk($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
            chk($sformatf("v%0d_ovf", i), ovf_cnt - o0, vecs[i].exp_ovf);
            chk($sformatf("v%0d_valid", i), keyboard_valid_data, vecs[i].exp_valid);
            chk($sformatf("v%0d_head", i), keyboard_data, vecs[i].exp_head);
        end
        drain(8'h11, 8'h22, 8'h33, 8'h44);
        // Timeout: clock stops after 5 falling edges.
        e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        for (k = 1; k <= T + 20; k++) begin
            @(negedge clk);
            if (k == H) ps2_clk = 1'b1;
            if (frame_error) break;
        end
        // T cycles of counting plus 3 cycles of sync/edge latency and 1 registered output.
        chk("tmo_delay", k, T + 4);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        chk("tmo_errs", err_cnt - e0, 1);
        chk("tmo_valid", keyboard_valid_data, 0);
        e0 = err_cnt;
        send_frame(8'h2A, 1'b0, 1'b1);
        chk("2a_valid", keyboard_valid_data, 1);
        chk("2a_data", keyboard_data, 8'h2A);
        chk("2a_err", err_cnt - e0, 0);
        pop1();
        // Push and pop in the same cycle while full.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1);
        o0 = ovf_cnt;
        send_head(8'h05, 1'b0);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("pp_head_before", keyboard_data, 8'h01);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("pp_head_after", keyboard_data, 8'h02);
        chk("pp_valid", keyboard_valid_data, 1);
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        chk("pp_ovf", ovf_cnt - o0, 0);
        drain(8'h02, 8'h03, 8'h04, 8'h05);
        // Pops on an empty FIFO and a lone high-data edge in IDLE are both no-ops.
        e0 = err_cnt;
        o0 = ovf_cnt;
        rd = 1'b1;
        repeat (10) @(negedge clk);
        rd = 1'b0;
        chk("emptypop_valid", keyboard_valid_data, 0);
        chk("emptypop_data", keyboard_data, 0);
        ps2_bit(1'b1);
        repeat (10) @(negedge clk);
        chk("lone_err", err_cnt - e0, 0);
        chk("lone_valid", keyboard_valid_data, 0);
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("after_valid", keyboard_valid_data, 1);
        chk("after_data", keyboard_data, 8'h3C);
        chk("after_err", err_cnt - e0, 0);
        chk("after_ovf", ovf_cnt - o0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
